ifu_fetch_queue: RTL and testbench
==================================

IFU_FETCH_QUEUE -- requirements
Module: ifu_fetch_queue

Interface
REQ-001 Parameter DEPTH, 8, number of queue entries; power of two, minimum 8.
REQ-002 Parameter RESET_PC, 32'h0, fetch address loaded at reset.
REQ-003 clk  in  1  single clock; all state SHALL update on posedge clk.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 redirect_valid  in  1  branch/exception redirect strobe.
REQ-006 redirect_pc  in  32  new fetch address.
REQ-007 cache_addr_out  out  32  word-aligned fetch address to I-cache.
REQ-008 cache_request_out  out  1  one-cycle fetch request pulse.
REQ-009 ins_count_out  out  3  instructions requested, 1..7.
REQ-010 cache_rdata_in  in  128  burst data; lane i occupies [32i+31:32i].
REQ-011 cache_rvalid_in  in  1  burst data valid, one cycle per burst.
REQ-012 cache_burst_done_in  in  1  all bursts of the current request delivered.
REQ-013 dec_instr0/dec_pc0, dec_instr1/dec_pc1  out  32 each  oldest and second-oldest entry.
REQ-014 dec_valid0, dec_valid1  out  1 each  entry present.
REQ-015 dec_accept  in  2  entries consumed by decode this cycle (0..2).

Function
REQ-016 The block SHALL hold a circular buffer of DEPTH {instr, pc} entries with head, tail, and count registers.
REQ-017 dec_valid0 SHALL be (count>=1) and dec_valid1 SHALL be (count>=2); dec outputs SHALL be combinational from head and head+1.
REQ-018 The effective dequeue SHALL be min(dec_accept, 2, count); any excess SHALL be ignored.
REQ-019 The FSM SHALL have states IDLE, REQ, WAIT and DROP.
REQ-020 IDLE: when free = DEPTH - count - dequeue_this_cycle >= 4, the FSM SHALL latch req_cnt = min(free, 7) and go to REQ.
REQ-021 REQ: cache_request_out SHALL be 1 for exactly this cycle, with cache_addr_out = fetch_pc and ins_count_out = req_cnt. The FSM SHALL then go to WAIT, set remaining = req_cnt, set burst_pc = fetch_pc, and advance fetch_pc by 4*req_cnt.
REQ-022 Free space for req_cnt entries SHALL be reserved from the REQ cycle until those entries are written; free in REQ-020 SHALL subtract outstanding reservations.
REQ-023 WAIT, cache_rvalid_in=1: lanes = min(remaining, 4). The block SHALL write lanes 0..lanes-1 at tail with pc = burst_pc + 4i, then advance tail, burst_pc, and count by lanes, and decrement remaining by lanes.
REQ-024 WAIT, cache_burst_done_in=1: the FSM SHALL go to IDLE; any nonzero remaining SHALL be released (not written).
REQ-025 On the same cycle, count SHALL change by enqueued lanes minus effective dequeue.
REQ-026 Pointer arithmetic SHALL be modulo DEPTH; wrap-around mid-burst SHALL split lanes correctly.
REQ-027 fetch_pc[1:0] SHALL always be 0; redirect_pc[1:0] SHALL be discarded.
REQ-028 redirect_valid in any state SHALL clear count, head, tail, and reservations, and SHALL set fetch_pc = {redirect_pc[31:2], 2'b00}. A redirect SHALL take priority over same-cycle enqueue and dequeue.
REQ-029 A redirect in REQ or WAIT SHALL send the FSM to DROP. A redirect in IDLE or DROP SHALL leave the state unchanged.
REQ-030 DROP: rvalid data SHALL be discarded; cache_burst_done_in SHALL move the FSM to IDLE.
REQ-031 A redirect while in REQ SHALL still complete the request pulse, but the returned data SHALL be dropped.
REQ-032 rvalid or burst_done in IDLE or REQ SHALL be ignored.

Reset
REQ-033 While reset=1, the FSM SHALL be in IDLE and count, head, tail, remaining, and reservations SHALL be 0.
REQ-034 While reset=1, fetch_pc SHALL equal RESET_PC, cache_request_out and ins_count_out SHALL be 0, and cache_addr_out SHALL equal RESET_PC.
REQ-035 While reset=1, dec_valid0/1 SHALL be 0 and dec_instr and dec_pc outputs SHALL be 0.
REQ-036 Reset asserted mid-burst SHALL abandon the burst; subsequent cache responses SHALL be ignored until a new request is issued.

Verification
REQ-037 Startup: release reset, cache model returns words equal to address -> first cycle after reset in IDLE, then pulse with addr 0x0, count 7. Bursts {0,4,8,C} then {10,14,18} are enqueued; count=7; dec_pc0=0x0, dec_pc1=0x4.
REQ-038 Dual dequeue: with 7 queued, dec_accept=2 for 3 cycles -> count 7,5,3,1 and dec_pc0 0x0, 0x8, 0x10, 0x18. A new request at 0x1C is issued once free>=4.
REQ-039 Full: hold dec_accept=0 -> no request while free<4; count never exceeds 8; no entry is overwritten.
REQ-040 Redirect during WAIT to 0x43 -> queue empty next cycle; late bursts are discarded; after done, a pulse with addr 0x40, count 7.
REQ-041 Wrap: head=tail=6 with 0 entries, 4-lane burst -> entries at indices 6,7,0,1 in PC order.
REQ-042 Over-accept: count=1, dec_accept=2 -> count 0, no underflow, dec_valid0=0.

Source files
------------

// File: rtl/ifu_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : ifu_fetch_queue
// Description : Instruction fetch queue. Issues I-cache fetch requests when
//               enough space is free, writes returned burst lanes into a
//               circular buffer of {instr, pc} entries and presents the two
//               oldest entries to decode. Redirects flush the queue and drop
//               any in-flight burst.
// Revision    : 1.0 - initial release
// ============================================================================
module ifu_fetch_queue #(
    parameter int          DEPTH    = 8,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         redirect_valid,
    input  logic [31:0]  redirect_pc,
    output logic [31:0]  cache_addr_out,
    output logic         cache_request_out,
    output logic [2:0]   ins_count_out,
    input  logic [127:0] cache_rdata_in,
    input  logic         cache_rvalid_in,
    input  logic         cache_burst_done_in,
    output logic [31:0]  dec_instr0,
    output logic [31:0]  dec_pc0,
    output logic [31:0]  dec_instr1,
    output logic [31:0]  dec_pc1,
    output logic         dec_valid0,
    output logic         dec_valid1,
    input  logic [1:0]   dec_accept
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int UW = CW + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DROP = 2'd3
    } state_t;

    state_t          r_state;
    logic [31:0]     r_mem_instr [DEPTH];
    logic [31:0]     r_mem_pc    [DEPTH];
    logic [PW-1:0]   r_head;
    logic [PW-1:0]   r_tail;
    logic [CW-1:0]   r_count;
    logic [CW-1:0]   r_resv;
    logic [2:0]      r_req_cnt;
    logic [2:0]      r_remaining;
    logic [31:0]     r_fetch_pc;
    logic [31:0]     r_burst_pc;

    logic [1:0]      w_acc;
    logic [1:0]      w_deq;
    logic [UW-1:0]   w_used;
    logic [CW-1:0]   w_free;
    logic [2:0]      w_req_cnt;
    logic [2:0]      w_lanes;
    logic            w_wr;
    logic [2:0]      w_enq;
    logic [PW-1:0]   w_head1;
    logic            w_unused_pc_lsbs;

    // Dequeue clamp, free-space and burst-lane arithmetic.
    always_comb begin
        w_acc     = (dec_accept == 2'd3) ? 2'd2 : dec_accept;
        w_deq     = (CW'(w_acc) > r_count) ? r_count[1:0] : w_acc;
        w_used    = {1'b0, r_count} + UW'(w_deq) + {1'b0, r_resv};
        // Saturate at zero: a full queue that is also dequeuing has no room.
        w_free    = (w_used >= UW'(DEPTH)) ? '0 : CW'(UW'(DEPTH) - w_used);
        w_req_cnt = (w_free >= CW'(7)) ? 3'd7 : w_free[2:0];
        w_lanes   = (r_remaining >= 3'd4) ? 3'd4 : r_remaining;
        w_wr      = (r_state == WAIT) && cache_rvalid_in;
        w_enq     = w_wr ? w_lanes : 3'd0;
        w_head1   = r_head + PW'(1);
    end

    // Only word addresses are fetched; the low redirect bits are dropped.
    assign w_unused_pc_lsbs = &{1'b0, redirect_pc[1:0]};

    assign cache_addr_out = r_fetch_pc;
    assign dec_valid0     = (r_count != '0);
    assign dec_valid1     = (r_count >= CW'(2));
    assign dec_instr0     = dec_valid0 ? r_mem_instr[r_head]  : 32'h0;
    assign dec_pc0        = dec_valid0 ? r_mem_pc[r_head]     : 32'h0;
    assign dec_instr1     = dec_valid1 ? r_mem_instr[w_head1] : 32'h0;
    assign dec_pc1        = dec_valid1 ? r_mem_pc[w_head1]    : 32'h0;

    // Entry storage: write the valid lanes of a burst, wrapping at DEPTH.
    always_ff @(posedge clk) begin
        if (w_wr && !redirect_valid && !reset) begin
            for (int i = 0; i < 4; i++) begin
                if (i < int'(w_lanes)) begin
                    r_mem_instr[r_tail + PW'(i)] <= cache_rdata_in[32*i +: 32];
                    r_mem_pc[r_tail + PW'(i)]    <= r_burst_pc + 32'(4 * i);
                end
            end
        end
    end

    // Fetch FSM, queue pointers, occupancy and reservations.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state           <= IDLE;
            r_head            <= '0;
            r_tail            <= '0;
            r_count           <= '0;
            r_resv            <= '0;
            r_req_cnt         <= 3'd0;
            r_remaining       <= 3'd0;
            r_fetch_pc        <= RESET_PC;
            r_burst_pc        <= RESET_PC;
            cache_request_out <= 1'b0;
            ins_count_out     <= 3'd0;
        end else if (redirect_valid) begin
            // Flush wins over any same-cycle enqueue or dequeue.
            r_head            <= '0;
            r_tail            <= '0;
            r_count           <= '0;
            r_resv            <= '0;
            r_remaining       <= 3'd0;
            r_fetch_pc        <= {redirect_pc[31:2], 2'b00};
            cache_request_out <= 1'b0;
            ins_count_out     <= 3'd0;
            if (r_state == REQ || r_state == WAIT) begin
                r_state <= DROP;
            end
        end else begin
            r_count           <= r_count + CW'(w_enq) - CW'(w_deq);
            r_head            <= r_head + PW'(w_deq);
            cache_request_out <= 1'b0;
            ins_count_out     <= 3'd0;
            case (r_state)
                IDLE: begin
                    if (w_free >= CW'(4)) begin
                        r_req_cnt         <= w_req_cnt;
                        cache_request_out <= 1'b1;
                        ins_count_out     <= w_req_cnt;
                        r_state           <= REQ;
                    end
                end
                REQ: begin
                    r_remaining <= r_req_cnt;
                    r_resv      <= CW'(r_req_cnt);
                    r_burst_pc  <= r_fetch_pc;
                    r_fetch_pc  <= r_fetch_pc + {27'd0, r_req_cnt, 2'b00};
                    r_state     <= WAIT;
                end
                WAIT: begin
                    if (cache_rvalid_in) begin
                        r_tail      <= r_tail + PW'(w_lanes);
                        r_burst_pc  <= r_burst_pc + {27'd0, w_lanes, 2'b00};
                        r_remaining <= r_remaining - w_lanes;
                        r_resv      <= r_resv - CW'(w_lanes);
                    end
                    if (cache_burst_done_in) begin
                        // Undelivered lanes are released, not written.
                        r_remaining <= 3'd0;
                        r_resv      <= '0;
                        r_state     <= IDLE;
                    end
                end
                DROP: begin
                    if (cache_burst_done_in) begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ifu_fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_ifu_fetch_queue
// Description : Directed self-checking bench for ifu_fetch_queue. The cache
//               side is driven by hand, returning words equal to addresses.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ifu_fetch_queue;

    logic         clk;
    logic         reset;
    logic         redirect_valid;
    logic [31:0]  redirect_pc;
    logic [31:0]  cache_addr_out;
    logic         cache_request_out;
    logic [2:0]   ins_count_out;
    logic [127:0] cache_rdata_in;
    logic         cache_rvalid_in;
    logic         cache_burst_done_in;
    logic [31:0]  dec_instr0;
    logic [31:0]  dec_pc0;
    logic [31:0]  dec_instr1;
    logic [31:0]  dec_pc1;
    logic         dec_valid0;
    logic         dec_valid1;
    logic [1:0]   dec_accept;

    int n_tests = 0;
    int n_fail  = 0;
    int pulses;

    ifu_fetch_queue #(
        .DEPTH    (8),
        .RESET_PC (32'h0)
    ) dut (
        .clk                 (clk),
        .reset               (reset),
        .redirect_valid      (redirect_valid),
        .redirect_pc         (redirect_pc),
        .cache_addr_out      (cache_addr_out),
        .cache_request_out   (cache_request_out),
        .ins_count_out       (ins_count_out),
        .cache_rdata_in      (cache_rdata_in),
        .cache_rvalid_in     (cache_rvalid_in),
        .cache_burst_done_in (cache_burst_done_in),
        .dec_instr0          (dec_instr0),
        .dec_pc0             (dec_pc0),
        .dec_instr1          (dec_instr1),
        .dec_pc1             (dec_pc1),
        .dec_valid0          (dec_valid0),
        .dec_valid1          (dec_valid1),
        .dec_accept          (dec_accept)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1 ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic burst(input logic [31:0] w0, input logic [31:0] w1,
                         input logic [31:0] w2, input logic [31:0] w3);
        cache_rdata_in  = {w3, w2, w1, w0};
        cache_rvalid_in = 1'b1;
        tick();
        cache_rvalid_in = 1'b0;
    endtask

    task automatic done_pulse();
        cache_burst_done_in = 1'b1;
        tick();
        cache_burst_done_in = 1'b0;
    endtask

    initial begin
        reset               = 1'b1;
        redirect_valid      = 1'b0;
        redirect_pc         = 32'h0;
        cache_rdata_in      = '0;
        cache_rvalid_in     = 1'b0;
        cache_burst_done_in = 1'b0;
        dec_accept          = 2'd0;
        repeat (3) tick();

        // Reset state
        check("rst_req",    32'(cache_request_out), 32'h0);
        check("rst_cnt",    32'(ins_count_out),     32'h0);
        check("rst_addr",   cache_addr_out,         32'h0);
        check("rst_v0",     32'(dec_valid0),        32'h0);
        check("rst_v1",     32'(dec_valid1),        32'h0);
        check("rst_pc0",    dec_pc0,                32'h0);

        // Startup: one idle cycle, then a 7-instruction request at 0x0
        reset = 1'b0;
        check("idle_first", 32'(cache_request_out), 32'h0);
        tick();
        check("st_req",     32'(cache_request_out), 32'h1);
        check("st_addr",    cache_addr_out,         32'h0);
        check("st_cnt",     32'(ins_count_out),     32'd7);
        tick();
        check("st_pulse1",  32'(cache_request_out), 32'h0);
        burst(32'h0, 32'h4, 32'h8, 32'hC);
        burst(32'h10, 32'h14, 32'h18, 32'hDEAD_BEEF);
        done_pulse();
        check("st_pc0",     dec_pc0,    32'h0);
        check("st_pc1",     dec_pc1,    32'h4);
        check("st_in1",     dec_instr1, 32'h4);
        check("st_v1",      32'(dec_valid1), 32'h1);
        tick();
        check("st_noreq",   32'(cache_request_out), 32'h0);

        // Dual dequeue: 7 -> 5 -> 3 -> 1
        dec_accept = 2'd2;
        tick();
        check("dd_pc0_a",   dec_pc0, 32'h8);
        check("dd_pc1_a",   dec_pc1, 32'hC);
        tick();
        check("dd_pc0_b",   dec_pc0, 32'h10);
        tick();
        check("dd_pc0_c",   dec_pc0, 32'h18);
        check("dd_v1_c",    32'(dec_valid1), 32'h0);
        check("dd_noreq",   32'(cache_request_out), 32'h0);
        dec_accept = 2'd0;
        tick();
        check("dd_req",     32'(cache_request_out), 32'h1);
        check("dd_addr",    cache_addr_out,         32'h1C);
        check("dd_cnt",     32'(ins_count_out),     32'd7);

        // Fill to 8 entries across the buffer wrap
        tick();
        burst(32'h1C, 32'h20, 32'h24, 32'h28);
        burst(32'h2C, 32'h30, 32'h34, 32'hDEAD_BEEF);
        done_pulse();
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            if (cache_request_out) pulses++;
            tick();
        end
        check("full_noreq", 32'(pulses), 32'h0);
        check("full_pc0",   dec_pc0, 32'h18);
        check("full_pc1",   dec_pc1, 32'h1C);

        // Drain in order: nothing overwritten
        dec_accept = 2'd2;
        tick();
        check("dr_pc0_a",   dec_pc0, 32'h20);
        check("dr_pc1_a",   dec_pc1, 32'h24);
        tick();
        check("dr_pc0_b",   dec_pc0, 32'h28);
        check("dr_pc1_b",   dec_pc1, 32'h2C);
        tick();
        check("dr_pc0_c",   dec_pc0, 32'h30);
        check("dr_pc1_c",   dec_pc1, 32'h34);
        check("dr_noreq",   32'(cache_request_out), 32'h0);
        dec_accept = 2'd1;
        tick();
        check("dr_pc0_d",   dec_pc0, 32'h34);
        check("dr_v1_d",    32'(dec_valid1), 32'h0);
        check("dr_req",     32'(cache_request_out), 32'h1);
        check("dr_addr",    cache_addr_out,         32'h38);
        check("dr_cnt",     32'(ins_count_out),     32'd5);

        // Over-accept with one entry left
        dec_accept = 2'd2;
        tick();
        check("oa_v0",      32'(dec_valid0), 32'h0);
        check("oa_v1",      32'(dec_valid1), 32'h0);
        tick();
        check("oa_v0_hold", 32'(dec_valid0), 32'h0);
        dec_accept = 2'd0;

        // Wrap: head=tail=6, 4-lane burst lands at 6,7,0,1
        burst(32'h38, 32'h3C, 32'h40, 32'h44);
        check("wr_pc0",     dec_pc0,    32'h38);
        check("wr_pc1",     dec_pc1,    32'h3C);
        check("wr_in0",     dec_instr0, 32'h38);
        dec_accept = 2'd2;
        tick();
        check("wr_pc0_b",   dec_pc0,    32'h40);
        check("wr_pc1_b",   dec_pc1,    32'h44);
        check("wr_in1_b",   dec_instr1, 32'h44);
        dec_accept = 2'd0;

        // Redirect in WAIT to an unaligned address
        redirect_valid = 1'b1;
        redirect_pc    = 32'h43;
        tick();
        redirect_valid = 1'b0;
        check("rd_v0",      32'(dec_valid0), 32'h0);
        check("rd_v1",      32'(dec_valid1), 32'h0);
        burst(32'h48, 32'h4C, 32'h50, 32'h54);
        check("rd_drop_v0", 32'(dec_valid0), 32'h0);
        done_pulse();
        check("rd_noreq",   32'(cache_request_out), 32'h0);
        tick();
        check("rd_req",     32'(cache_request_out), 32'h1);
        check("rd_addr",    cache_addr_out,         32'h40);
        check("rd_cnt",     32'(ins_count_out),     32'd7);

        // Reset mid-burst: later responses ignored until a new request
        tick();
        reset = 1'b1;
        tick();
        cache_rdata_in  = {32'h4C, 32'h48, 32'h44, 32'h40};
        cache_rvalid_in = 1'b1;
        tick();
        check("mr_v0",      32'(dec_valid0),        32'h0);
        check("mr_req",     32'(cache_request_out), 32'h0);
        check("mr_cnt",     32'(ins_count_out),     32'h0);
        check("mr_addr",    cache_addr_out,         32'h0);
        reset               = 1'b0;
        cache_burst_done_in = 1'b1;
        tick();
        cache_rvalid_in     = 1'b0;
        cache_burst_done_in = 1'b0;
        check("mr_v0_post", 32'(dec_valid0),        32'h0);
        check("mr_req_new", 32'(cache_request_out), 32'h1);
        check("mr_addr_new", cache_addr_out,        32'h0);
        check("mr_cnt_new", 32'(ins_count_out),     32'd7);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
